id_issue_ctrl: RTL and testbench
================================

Name: id_issue_ctrl

Overview:
- Producer-side controller for the ID/EX pipeline register. It decides each cycle whether the decoded instruction is issued into EX or replaced by a bubble (all-zero controls).
- Tracks in-flight register writers in a 3-entry scoreboard (EX, MEM, WB) to enforce RAW interlocks.
- Handles taken-branch flushes from EX and sequences HLT: drain, then halt.
- Sits between the decoder and the ID/EX register. Its `issue` output gates the ID_* bundle; when `issue`=0 the top level drives zeros.

Parameters:
- ZERO_REG, 1, register 0 is hardwired zero and never causes a hazard (0 = treat r0 like any register)
- DRAIN_CYCLES, 3, cycles spent in DRAIN after HLT issues, before `halted` asserts
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  ID holds a real instruction
- dec_src1  in  5  source register 1
- dec_src1_used  in  1  src1 is read
- dec_src2  in  5  source register 2
- dec_src2_used  in  1  src2 is read
- dec_dst_reg  in  5  destination register
- dec_wb_we  in  1  instruction writes the register file
- dec_wb_mem_sel  in  1  write-back data comes from memory (load)
- dec_hlt  in  1  instruction is HLT
- ex_flush  in  1  branch/jump resolved taken in EX this cycle
- issue  out  1  pass decoded controls into ID/EX this edge
- stall  out  1  hold PC and IF/ID this edge
- if_id_flush  out  1  zero IF/ID this edge
- halted  out  1  core halted
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset (at a rising edge with `rst`=1):
  - Scoreboard entries become invalid.
  - FSM goes to RUN.
  - `stall_cnt` becomes 0.
- While `rst`=1, combinational outputs are forced: `issue`=0, `stall`=0, `if_id_flush`=0. `halted` is registered and reads 0 after reset.
- Output timing: `issue`, `stall` and `if_id_flush` are combinational from current state and dec_*/`ex_flush` (zero-cycle latency), because they gate the same edge's register captures.
- Scoreboard entry format: {valid, dst[4:0], is_load}.
  - Each edge: WB <= MEM, MEM <= EX.
  - EX <= {issue & dec_wb_we, dec_dst_reg, dec_wb_mem_sel}.
  - A bubble loads an invalid entry.
- Hazard (`haz`), default build with forwarding: a used source matches a valid EX entry that has is_load=1. This is the load-use case and costs 1 stall.
  - If ZERO_REG=1, a source equal to 0 never matches.
- FSM RUN:
  - `ex_flush`=1: `issue`=0, `if_id_flush`=1, `stall`=0. Flush wins over `haz` and over `dec_hlt`.
  - Else `dec_valid` & `haz`: `issue`=0, `stall`=1. `stall_cnt` increments and saturates at all-ones.
  - Else: `issue`=`dec_valid`.
  - If the instruction issues with `dec_hlt`=1, go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
- FSM DRAIN:
  - `issue`=0, `stall`=1. `ex_flush` is ignored, since HLT is the youngest instruction in flight.
  - Counter decrements each cycle. At 0, go to HALTED.
  - Stall cycles in DRAIN do not increment `stall_cnt`.
- FSM HALTED:
  - `halted`=1, `issue`=0, `stall`=1.
  - Left only by `rst`.
- Simultaneous hazard and flush: flush only. The stalled instruction is discarded, not retried.
- Reset mid-DRAIN: returns to RUN with an empty scoreboard on the next edge.

Optional Feature:
- Macro: FULL_INTERLOCK_EN.
- Defined (core built without forwarding paths): `haz` = a used source matches any valid entry in EX or MEM, whether or not it is a load. The register file writes before it reads, so WB is excluded. A dependent directly behind an ALU op stalls 2 cycles; one instruction behind, 1 cycle.
- Undefined: load-use-only rule above.

Decomposition:
- Package id_issue_pkg holds:
  - FSM enum {RUN, DRAIN, HALTED}
  - packed struct sb_entry_t {valid, dst, is_load}
  - REG_ZERO constant
- One sub-module, hazard_scoreboard:
  - owns the 3-stage shift of sb_entry_t
  - takes the src1/src2 compare inputs and produces `haz`
  - includes the FULL_INTERLOCK_EN selection
- id_issue_ctrl keeps the FSM, the drain counter and `stall_cnt`.

Test Plan:
- Load r3, then add r4=r3+r1 back-to-back (default build) -> 1 cycle with `stall`=1 and `issue`=0, then `issue`=1; `stall_cnt`=1.
- ALU writes r5, dependent next: default -> 0 stalls. FULL_INTERLOCK_EN -> 2 stalls; with one independent instruction between -> 1 stall.
- Load r0, then a reader of r0 with ZERO_REG=1 -> no stall. With ZERO_REG=0 -> 1 stall.
- `ex_flush`=1 in the same cycle as a load-use hazard -> `if_id_flush`=1, `issue`=0, `stall`=0, `stall_cnt` unchanged; the next instruction issues without stalling.
- HLT issues -> `stall`=1 for 3 DRAIN cycles, then `halted`=1 and it stays there. Pulsing `ex_flush` during DRAIN has no effect. `rst` then gives `halted`=0 and FSM RUN.
- Force 65,540 consecutive hazard cycles -> `stall_cnt` saturates at 16'hFFFF. Reset clears it to 0 on the next edge.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared types and helpers for the ID-stage issue controller and its hazard scoreboard.
package id_issue_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       is_load;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam sb_entry_t  SB_EMPTY = '0;

  // A used source that names an in-flight writer; r0 is exempt when it is hardwired.
  function automatic logic src_hit(input logic [4:0] src, input logic used,
                                   input sb_entry_t e, input logic zero_reg);
    return used && e.valid && (e.dst == src) && !(zero_reg && (src == REG_ZERO));
  endfunction

endpackage

// File: rtl/id_issue_ctrl_scoreboard.sv
// In-flight writer tracking (EX, MEM, WB) and RAW hazard detection.
// Build option FULL_INTERLOCK_EN: no forwarding, so any EX/MEM writer interlocks.
module hazard_scoreboard
  import id_issue_pkg::*;
#(
  parameter int ZERO_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic       dec_wb_we,
  input  logic [4:0] dec_dst_reg,
  input  logic       dec_wb_mem_sel,
  input  logic [4:0] dec_src1,
  input  logic       dec_src1_used,
  input  logic [4:0] dec_src2,
  input  logic       dec_src2_used,
  output logic       haz
);

  localparam logic ZR = (ZERO_REG != 0);

  sb_entry_t sb_ex, sb_mem, sb_wb;
  logic      unused_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex  <= SB_EMPTY;
      sb_mem <= SB_EMPTY;
      sb_wb  <= SB_EMPTY;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= '{valid: issue & dec_wb_we, dst: dec_dst_reg, is_load: dec_wb_mem_sel};
    end
  end

  // WB is tracked for completeness; the register file writes before it reads.
  assign unused_wb = ^sb_wb;

  logic hit_ex;
  assign hit_ex = src_hit(dec_src1, dec_src1_used, sb_ex, ZR) |
                  src_hit(dec_src2, dec_src2_used, sb_ex, ZR);

`ifdef FULL_INTERLOCK_EN
  logic hit_mem;
  assign hit_mem = src_hit(dec_src1, dec_src1_used, sb_mem, ZR) |
                   src_hit(dec_src2, dec_src2_used, sb_mem, ZR);
  assign haz     = hit_ex | hit_mem;
`else
  assign haz     = hit_ex & sb_ex.is_load;
`endif

endmodule

// File: rtl/id_issue_ctrl.sv
// ID/EX issue controller: RAW interlock stalls, EX flush handling, HLT drain/halt.
// Hazard rule selected by FULL_INTERLOCK_EN (see hazard_scoreboard).
module id_issue_ctrl
  import id_issue_pkg::*;
#(
  parameter int ZERO_REG     = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_src1,
  input  logic             dec_src1_used,
  input  logic [4:0]       dec_src2,
  input  logic             dec_src2_used,
  input  logic [4:0]       dec_dst_reg,
  input  logic             dec_wb_we,
  input  logic             dec_wb_mem_sel,
  input  logic             dec_hlt,
  input  logic             ex_flush,
  output logic             issue,
  output logic             stall,
  output logic             if_id_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t          state_q, next_state;
  logic [DW-1:0]   drain_cnt;
  logic            drain_load;
  logic            cnt_inc;
  logic            haz;

  hazard_scoreboard #(
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue),
    .dec_wb_we     (dec_wb_we),
    .dec_dst_reg   (dec_dst_reg),
    .dec_wb_mem_sel(dec_wb_mem_sel),
    .dec_src1      (dec_src1),
    .dec_src1_used (dec_src1_used),
    .dec_src2      (dec_src2),
    .dec_src2_used (dec_src2_used),
    .haz           (haz)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= next_state;
  end

  always_comb begin
    next_state  = state_q;
    issue       = 1'b0;
    stall       = 1'b0;
    if_id_flush = 1'b0;
    drain_load  = 1'b0;
    cnt_inc     = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          // A taken branch discards the ID instruction, even a stalled one.
          if (ex_flush) begin
            if_id_flush = 1'b1;
          end else if (dec_valid && haz) begin
            stall   = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            issue = dec_valid;
            if (dec_valid && dec_hlt) begin
              next_state = DRAIN;
              drain_load = 1'b1;
            end
          end
        end
        DRAIN: begin
          stall = 1'b1;
          if (drain_cnt == '0) next_state = HALTED;
        end
        HALTED: begin
          stall = 1'b1;
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (drain_load)
        drain_cnt <= DRAIN_LOAD;
      else if (state_q == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DW'(1);
      if (cnt_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench for id_issue_ctrl: directed cycles push expectations, a negedge monitor checks them.
module tb_id_issue_ctrl;

`ifdef FULL_INTERLOCK_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_src1_used, dec_src2_used, dec_wb_we, dec_wb_mem_sel, dec_hlt, ex_flush;
  logic [4:0]  dec_src1, dec_src2, dec_dst_reg;
  logic        issue, stall, if_id_flush, halted;
  logic [15:0] stall_cnt;
  logic        z0_issue, z0_stall, z0_flush_unused, z0_halted_unused;
  logic [15:0] z0_cnt_unused;
  logic        sat_issue_unused, sat_stall_unused, sat_flush_unused, sat_halted_unused;
  logic [2:0]  sat_cnt;

  always #5 clk = ~clk;

  id_issue_ctrl dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src1_used(dec_src1_used),
    .dec_src2(dec_src2), .dec_src2_used(dec_src2_used), .dec_dst_reg(dec_dst_reg), .dec_wb_we(dec_wb_we),
    .dec_wb_mem_sel(dec_wb_mem_sel), .dec_hlt(dec_hlt), .ex_flush(ex_flush), .issue(issue), .stall(stall),
    .if_id_flush(if_id_flush), .halted(halted), .stall_cnt(stall_cnt));

  id_issue_ctrl #(.ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src1_used(dec_src1_used),
    .dec_src2(dec_src2), .dec_src2_used(dec_src2_used), .dec_dst_reg(dec_dst_reg), .dec_wb_we(dec_wb_we),
    .dec_wb_mem_sel(dec_wb_mem_sel), .dec_hlt(dec_hlt), .ex_flush(ex_flush), .issue(z0_issue), .stall(z0_stall),
    .if_id_flush(z0_flush_unused), .halted(z0_halted_unused), .stall_cnt(z0_cnt_unused));

  id_issue_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src1_used(dec_src1_used),
    .dec_src2(dec_src2), .dec_src2_used(dec_src2_used), .dec_dst_reg(dec_dst_reg), .dec_wb_we(dec_wb_we),
    .dec_wb_mem_sel(dec_wb_mem_sel), .dec_hlt(dec_hlt), .ex_flush(ex_flush), .issue(sat_issue_unused),
    .stall(sat_stall_unused), .if_id_flush(sat_flush_unused), .halted(sat_halted_unused), .stall_cnt(sat_cnt));

  typedef struct {
    logic        issue, stall, flush, halted;
    logic [15:0] cnt;
    bit          chk_z0;
    logic        z0_stall;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ec    = 0;
  bit   z0_chk = 1'b0;
  logic z0_want = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] sw;
    if (q.size() > 0) begin
      e  = q.pop_front();
      sw = (e.cnt > 16'd7) ? 16'd7 : e.cnt;
      chk({e.nm, "/issue"},  {15'd0, issue},       {15'd0, e.issue});
      chk({e.nm, "/stall"},  {15'd0, stall},       {15'd0, e.stall});
      chk({e.nm, "/flush"},  {15'd0, if_id_flush}, {15'd0, e.flush});
      chk({e.nm, "/halted"}, {15'd0, halted},      {15'd0, e.halted});
      chk({e.nm, "/cnt"},    stall_cnt,            e.cnt);
      chk({e.nm, "/satcnt"}, {13'd0, sat_cnt},     sw);
      if (e.chk_z0) begin
        chk({e.nm, "/z0stall"}, {15'd0, z0_stall}, {15'd0, e.z0_stall});
        chk({e.nm, "/z0issue"}, {15'd0, z0_issue}, {15'd0, ~e.z0_stall});
      end
    end
  end

  task automatic push(input bit ei, input bit es, input bit ef, input bit eh, input string nm);
    exp_t e;
    e.issue = ei; e.stall = es; e.flush = ef; e.halted = eh;
    e.cnt = 16'(ec); e.chk_z0 = z0_chk; e.z0_stall = z0_want; e.nm = nm;
    q.push_back(e);
  endtask

  // One cycle: decoded instruction, ex_flush, and the expected outputs. hz marks a counted stall.
  task automatic go(input int s1, input bit u1, input int s2, input bit u2, input int d, input bit we,
                    input bit ld, input bit hlt, input bit v, input bit fl,
                    input bit ei, input bit es, input bit ef, input bit eh, input bit hz, input string nm);
    @(posedge clk); #1;
    rst = 1'b0; dec_valid = v; ex_flush = fl; dec_hlt = hlt;
    dec_src1 = 5'(s1); dec_src1_used = u1; dec_src2 = 5'(s2); dec_src2_used = u2;
    dec_dst_reg = 5'(d); dec_wb_we = we; dec_wb_mem_sel = ld;
    push(ei, es, ef, eh, nm);
    if (hz) ec++;
  endtask

  task automatic nop(input bit es, input bit eh, input string nm);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, 0, eh, 0, nm);
  endtask

  // Reset cycle with hazard-looking inputs and a flush: outputs must still read zero.
  task automatic rst_cyc(input bit eh, input string nm);
    @(posedge clk); #1;
    rst = 1'b1; dec_valid = 1'b1; ex_flush = 1'b1; dec_hlt = 1'b1;
    dec_src1 = 5'd3; dec_src1_used = 1'b1; dec_src2 = 5'd0; dec_src2_used = 1'b0;
    dec_dst_reg = 5'd3; dec_wb_we = 1'b1; dec_wb_mem_sel = 1'b1;
    push(0, 0, 0, eh, nm);
    ec = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dec_valid = 0; dec_src1 = 0; dec_src1_used = 0; dec_src2 = 0; dec_src2_used = 0;
    dec_dst_reg = 0; dec_wb_we = 0; dec_wb_mem_sel = 0; dec_hlt = 0; ex_flush = 0;
    @(posedge clk);
    rst_cyc(0, "rst");

    // load r3; add r4 = r3 + r1
    go(0, 0, 0, 0, 3, 1, 1, 0, 1, 0,   1, 0, 0, 0, 0, "lu_load");
    go(3, 1, 1, 1, 4, 1, 0, 0, 1, 0,   0, 1, 0, 0, 1, "lu_stall");
    if (FI) go(3, 1, 1, 1, 4, 1, 0, 0, 1, 0,   0, 1, 0, 0, 1, "lu_stall2");
    go(3, 1, 1, 1, 4, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "lu_issue");
    repeat (3) nop(0, 0, "lu_nop");

    // ALU r5, dependent back-to-back
    go(0, 0, 0, 0, 5, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "alu_w5");
    if (FI) begin
      go(5, 1, 2, 1, 6, 1, 0, 0, 1, 0,   0, 1, 0, 0, 1, "alu_dep_st1");
      go(5, 1, 2, 1, 6, 1, 0, 0, 1, 0,   0, 1, 0, 0, 1, "alu_dep_st2");
    end
    go(5, 1, 2, 1, 6, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "alu_dep");
    repeat (3) nop(0, 0, "alu_nop");

    // ALU r5, independent, dependent
    go(0, 0, 0, 0, 5, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "gap_w5");
    go(1, 1, 0, 0, 7, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "gap_indep");
    if (FI) go(5, 1, 0, 0, 6, 1, 0, 0, 1, 0,   0, 1, 0, 0, 1, "gap_dep_st");
    go(5, 1, 0, 0, 6, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "gap_dep");
    repeat (3) nop(0, 0, "gap_nop");

    // load r0; reader of r0 (ZERO_REG=1 main, ZERO_REG=0 second instance)
    z0_chk = 1'b1; z0_want = 1'b0;
    go(0, 0, 0, 0, 0, 1, 1, 0, 1, 0,   1, 0, 0, 0, 0, "r0_load");
    z0_want = 1'b1;
    go(0, 1, 0, 0, 8, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "r0_read");
    z0_chk = 1'b0; z0_want = 1'b0;
    repeat (3) nop(0, 0, "r0_nop");

    // flush on a load-use hazard; flush beats HLT
    go(0, 0, 0, 0, 3, 1, 1, 0, 1, 0,   1, 0, 0, 0, 0, "fl_load");
    go(3, 1, 0, 0, 9, 1, 0, 0, 1, 1,   0, 0, 1, 0, 0, "fl_haz");
    go(1, 1, 0, 0, 10, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, "fl_next");
    go(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,   0, 0, 1, 0, 0, "fl_hlt");
    nop(0, 0, "fl_hlt_run");
    repeat (2) nop(0, 0, "fl_nop");

    // HLT drain and halt, flush ignored
    go(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 0, "hlt_issue");
    go(1, 1, 0, 0, 2, 1, 0, 0, 1, 1,   0, 1, 0, 0, 0, "drain1");
    nop(1, 0, "drain2");
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, "drain3");
    go(1, 1, 0, 0, 2, 1, 0, 0, 1, 0,   0, 1, 0, 1, 0, "halted1");
    go(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, "halted2");
    nop(1, 1, "halted3");
    rst_cyc(1, "rst_halt");
    nop(0, 0, "post_rst");
    go(1, 1, 0, 0, 2, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "post_rst_issue");

    // reset in the middle of DRAIN
    go(0, 0, 0, 0, 3, 1, 1, 0, 1, 0,   1, 0, 0, 0, 0, "md_load");
    go(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 0, "md_hlt");
    nop(1, 0, "md_drain");
    rst_cyc(0, "md_rst");
    go(3, 1, 0, 0, 4, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, "md_run");

    // stall counter saturation on the 3-bit instance
    repeat (10) begin
      go(1, 1, 0, 0, 1, 1, 1, 0, 1, 0,   1, 0, 0, 0, 0, "sat_iss");
      go(1, 1, 0, 0, 1, 1, 1, 0, 1, 0,   0, 1, 0, 0, 1, "sat_st");
      if (FI) go(1, 1, 0, 0, 1, 1, 1, 0, 1, 0,   0, 1, 0, 0, 1, "sat_st2");
    end
    nop(0, 0, "sat_cnt");
    rst_cyc(0, "sat_rst");
    nop(0, 0, "sat_clr");
    nop(0, 0, "end_nop");

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
